core_vx_ptw: RTL and testbench

CORE_VX_PTW -- requirements
Module: corevx_ptw

---
 rtl/core_vx_ptw.sv | 158 +++++++++++++++
 tb/tb_core_vx_ptw.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_vx_ptw.sv
// Two-level (Sv32-style) page table walker: 20-bit VPN, 22-bit PPN, 34-bit bus address.
// Superpage (level-1 leaf) support is enabled by defining COREVX_PTW_SUPERPAGE_EN.
module core_vx_ptw (
    input  logic        clk,
    input  logic        rst,
    input  logic        resolve_request,
    input  logic [19:0] resolve_virtual_address,
    input  logic [21:0] csr_satp_ppn_r,
    output logic        resolve_busy,
    output logic        resolve_done,
    output logic        resolve_pagefault,
    output logic        resolve_accessfault,
    output logic [7:0]  resolve_access_bits,
    output logic [21:0] resolve_physical_address,
    output logic [33:0] m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic        m_readdatavalid,
    input  logic [31:0] m_readdata,
    input  logic [1:0]  m_response
);

    // state | meaning
    // IDLE  | waiting for resolve_request
    // ISSUE | read of current-level PTE on the bus
    // WAIT  | waiting for read data, PTE evaluated on arrival
    // DONE  | one-cycle completion pulse
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        level_q, level_d;
    logic [19:0] vpn_q, vpn_d;
    logic [21:0] satp_q, satp_d;
    logic [21:0] pte_ppn_q, pte_ppn_d;
    logic        pf_q, pf_d;
    logic        af_q, af_d;
    logic [7:0]  bits_q, bits_d;
    logic [21:0] phys_q, phys_d;

    logic pte_v, pte_r, pte_w, pte_x;
    assign pte_v = m_readdata[0];
    assign pte_r = m_readdata[1];
    assign pte_w = m_readdata[2];
    assign pte_x = m_readdata[3];

    // RSW bits carry no meaning for translation
    logic unused_rsw;
    assign unused_rsw = ^m_readdata[9:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            level_q   <= 1'b0;
            vpn_q     <= '0;
            satp_q    <= '0;
            pte_ppn_q <= '0;
            pf_q      <= 1'b0;
            af_q      <= 1'b0;
            bits_q    <= '0;
            phys_q    <= '0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            vpn_q     <= vpn_d;
            satp_q    <= satp_d;
            pte_ppn_q <= pte_ppn_d;
            pf_q      <= pf_d;
            af_q      <= af_d;
            bits_q    <= bits_d;
            phys_q    <= phys_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        vpn_d     = vpn_q;
        satp_d    = satp_q;
        pte_ppn_d = pte_ppn_q;
        pf_d      = pf_q;
        af_d      = af_q;
        bits_d    = bits_q;
        phys_d    = phys_q;

        resolve_busy = (state_q != IDLE);
        resolve_done = (state_q == DONE);
        m_read       = (state_q == ISSUE);
        m_address    = '0;
        if (state_q == ISSUE) begin
            m_address = level_q ? {satp_q, vpn_q[19:10], 2'b00}
                                : {pte_ppn_q, vpn_q[9:0], 2'b00};
        end

        case (state_q)
            IDLE: begin
                if (resolve_request) begin
                    vpn_d     = resolve_virtual_address;
                    satp_d    = csr_satp_ppn_r;
                    level_d   = 1'b1;
                    pte_ppn_d = '0;
                    pf_d      = 1'b0;
                    af_d      = 1'b0;
                    bits_d    = '0;
                    phys_d    = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (!m_waitrequest) state_d = WAIT;
            end
            WAIT: begin
                if (m_readdatavalid) begin
                    state_d = DONE;
                    if (m_response != 2'b00) begin
                        af_d = 1'b1;
                    end else if (!pte_v || (!pte_r && pte_w)) begin
                        pf_d = 1'b1;
                    end else if (pte_r || pte_x) begin
                        if (level_q) begin
`ifdef COREVX_PTW_SUPERPAGE_EN
                            // a megapage must be 4 MiB aligned: low PPN field zero
                            if (m_readdata[19:10] != 10'd0) begin
                                pf_d = 1'b1;
                            end else begin
                                bits_d = m_readdata[7:0];
                                phys_d = {m_readdata[31:20], vpn_q[9:0]};
                            end
`else
                            pf_d = 1'b1;
`endif
                        end else begin
                            bits_d = m_readdata[7:0];
                            phys_d = m_readdata[31:10];
                        end
                    end else if (level_q) begin
                        pte_ppn_d = m_readdata[31:10];
                        level_d   = 1'b0;
                        state_d   = ISSUE;
                    end else begin
                        pf_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign resolve_pagefault        = pf_q;
    assign resolve_accessfault      = af_q;
    assign resolve_access_bits      = bits_q;
    assign resolve_physical_address = phys_q;

endmodule

// File: tb/tb_core_vx_ptw.sv
// Directed, table-driven bench for core_vx_ptw with a scripted memory responder.
// Expectations for level-1 leaves follow COREVX_PTW_SUPERPAGE_EN.
module tb_core_vx_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_request;
    logic [19:0] resolve_virtual_address;
    logic [21:0] csr_satp_ppn_r;
    logic        resolve_busy;
    logic        resolve_done;
    logic        resolve_pagefault;
    logic        resolve_accessfault;
    logic [7:0]  resolve_access_bits;
    logic [21:0] resolve_physical_address;
    logic [33:0] m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic        m_readdatavalid;
    logic [31:0] m_readdata;
    logic [1:0]  m_response;

    core_vx_ptw dut (
        .clk                      (clk),
        .rst                      (rst),
        .resolve_request          (resolve_request),
        .resolve_virtual_address  (resolve_virtual_address),
        .csr_satp_ppn_r           (csr_satp_ppn_r),
        .resolve_busy             (resolve_busy),
        .resolve_done             (resolve_done),
        .resolve_pagefault        (resolve_pagefault),
        .resolve_accessfault      (resolve_accessfault),
        .resolve_access_bits      (resolve_access_bits),
        .resolve_physical_address (resolve_physical_address),
        .m_address                (m_address),
        .m_read                   (m_read),
        .m_waitrequest            (m_waitrequest),
        .m_readdatavalid          (m_readdatavalid),
        .m_readdata               (m_readdata),
        .m_response               (m_response)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [21:0] satp;
        logic [19:0] vpn;
        logic [31:0] pte1;
        logic [1:0]  resp1;
        logic [31:0] pte2;
        logic [1:0]  resp2;
        int          wr;
        logic [33:0] a1;
        logic [33:0] a2;
        logic        pf;
        logic        af;
        logic [7:0]  bits;
        logic [21:0] phys;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic run_vec(input vec_t v, input int idx);
        int   cyc;
        int   nrd;
        int   wr_left;
        logic pending;
        bit   done_seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        resolve_request         = 1'b1;
        resolve_virtual_address = v.vpn;
        csr_satp_ppn_r          = v.satp;
        m_readdatavalid         = 1'b0;
        @(posedge clk);
        cyc = 0; nrd = 0; wr_left = v.wr; pending = 1'b0; done_seen = 1'b0;
        while (!done_seen && cyc < 40) begin
            @(negedge clk);
            cyc++;
            // keep a conflicting request asserted early on: it must be ignored while busy
            resolve_request         = (cyc < 3);
            resolve_virtual_address = 20'hFFFFF;
            csr_satp_ppn_r          = 22'h3FFFFF;
            m_readdatavalid = 1'b0;
            m_readdata      = 32'hDEADBEEF;
            m_response      = 2'b00;
            m_waitrequest   = 1'b0;
            if (cyc == 1) begin
                chk({tag, "_busy"}, resolve_busy, 1'b1);
                chk({tag, "_clr_pf"}, resolve_pagefault, 1'b0);
                chk({tag, "_clr_af"}, resolve_accessfault, 1'b0);
                chk({tag, "_clr_bits"}, resolve_access_bits, 8'h00);
                chk({tag, "_clr_phys"}, resolve_physical_address, 22'h0);
            end
            if (pending && !m_read) begin
                m_readdatavalid = 1'b1;
                m_readdata      = (nrd == 1) ? v.pte1 : v.pte2;
                m_response      = (nrd == 1) ? v.resp1 : v.resp2;
                pending         = 1'b0;
            end
            if (m_read) begin
                chk({tag, "_addr"}, m_address, (nrd == 0) ? v.a1 : v.a2);
                if (wr_left > 0) begin
                    m_waitrequest = 1'b1;
                    wr_left--;
                end else begin
                    nrd++;
                    pending = 1'b1;
                end
            end
            if (resolve_done) begin
                done_seen = 1'b1;
                chk({tag, "_lat"}, 34'(cyc), 34'(v.lat));
                chk({tag, "_pf"}, resolve_pagefault, v.pf);
                chk({tag, "_af"}, resolve_accessfault, v.af);
                chk({tag, "_bits"}, resolve_access_bits, v.bits);
                chk({tag, "_phys"}, resolve_physical_address, v.phys);
            end
        end
        resolve_request = 1'b0;
        if (!done_seen) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: got no done pulse, expected done at cycle %0d", tag, v.lat);
        end
        @(negedge clk);
        chk({tag, "_done_1cyc"}, resolve_done, 1'b0);
        chk({tag, "_idle"}, resolve_busy, 1'b0);
        chk({tag, "_hold_pf"}, resolve_pagefault, v.pf);
        chk({tag, "_hold_bits"}, resolve_access_bits, v.bits);
        chk({tag, "_hold_phys"}, resolve_physical_address, v.phys);
    endtask

    initial begin
        //          satp       vpn        pte1          r1     pte2          r2     wr a1             a2             pf    af    bits   phys        lat
        vecs[0] = '{22'h1,     20'h00403, 32'h00000801, 2'd0, 32'h000030CF, 2'd0, 0, 34'h1004,      34'h200C,      1'b0, 1'b0, 8'hCF, 22'h0000C,  5};
`ifdef COREVX_PTW_SUPERPAGE_EN
        vecs[1] = '{22'h1,     20'h00155, 32'h004000CB, 2'd0, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b0, 1'b0, 8'hCB, 22'h01155,  3};
`else
        vecs[1] = '{22'h1,     20'h00155, 32'h004000CB, 2'd0, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b1, 1'b0, 8'h00, 22'h0,      3};
`endif
        vecs[2] = '{22'h1,     20'h00155, 32'h000004CB, 2'd0, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b1, 1'b0, 8'h00, 22'h0,      3};
        vecs[3] = '{22'h1,     20'h00155, 32'h00000005, 2'd0, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b1, 1'b0, 8'h00, 22'h0,      3};
        vecs[4] = '{22'h1,     20'h00403, 32'h00000801, 2'd0, 32'h00000001, 2'd0, 0, 34'h1004,      34'h200C,      1'b1, 1'b0, 8'h00, 22'h0,      5};
        vecs[5] = '{22'h1,     20'h00403, 32'h00000801, 2'd0, 32'h000030CF, 2'd2, 0, 34'h1004,      34'h200C,      1'b0, 1'b1, 8'h00, 22'h0,      5};
        vecs[6] = '{22'h1,     20'h00403, 32'h00000801, 2'd0, 32'h000030CF, 2'd0, 3, 34'h1004,      34'h200C,      1'b0, 1'b0, 8'hCF, 22'h0000C,  8};
        vecs[7] = '{22'h1,     20'h00155, 32'h000000CE, 2'd0, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b1, 1'b0, 8'h00, 22'h0,      3};
        vecs[8] = '{22'h1,     20'h00155, 32'h000030CF, 2'd1, 32'h0,         2'd0, 0, 34'h1000,      34'h0,         1'b0, 1'b1, 8'h00, 22'h0,      3};
        vecs[9] = '{22'h3FFFFF, 20'hABCDE, 32'hFFFFFC01, 2'd0, 32'h123454C3, 2'd0, 0, 34'h3FFFFFABC, 34'h3FFFFF378, 1'b0, 1'b0, 8'hC3, 22'h048D15, 5};

        rst = 1'b1;
        resolve_request = 1'b0;
        resolve_virtual_address = '0;
        csr_satp_ppn_r = '0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
        m_response = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", resolve_busy, 1'b0);
        chk("rst_done", resolve_done, 1'b0);
        chk("rst_mread", m_read, 1'b0);
        chk("rst_maddr", m_address, 34'h0);
        chk("rst_pf", resolve_pagefault, 1'b0);
        chk("rst_af", resolve_accessfault, 1'b0);
        chk("rst_bits", resolve_access_bits, 8'h00);
        chk("rst_phys", resolve_physical_address, 22'h0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

        // reset while ISSUE is stalled by waitrequest
        @(negedge clk);
        resolve_request = 1'b1; resolve_virtual_address = 20'h00403; csr_satp_ppn_r = 22'h1;
        @(posedge clk);
        @(negedge clk);
        resolve_request = 1'b0;
        m_waitrequest = 1'b1;
        chk("rsti_mread_pre", m_read, 1'b1);
        chk("rsti_maddr_pre", m_address, 34'h1004);
        rst = 1'b1;
        #1;
        chk("rsti_mread", m_read, 1'b0);
        chk("rsti_maddr", m_address, 34'h0);
        chk("rsti_busy", resolve_busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_waitrequest = 1'b0;

        // reset during WAIT, then a stale readdatavalid arrives in IDLE
        @(negedge clk);
        resolve_request = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resolve_request = 1'b0;
        @(negedge clk);
        chk("rstw_busy_pre", resolve_busy, 1'b1);
        chk("rstw_mread_pre", m_read, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstw_busy", resolve_busy, 1'b0);
        chk("rstw_mread", m_read, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_readdatavalid = 1'b1; m_readdata = 32'h000030CF; m_response = 2'b00;
        @(negedge clk);
        m_readdatavalid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("stale_done%0d", k), resolve_done, 1'b0);
            chk($sformatf("stale_busy%0d", k), resolve_busy, 1'b0);
            chk($sformatf("stale_bits%0d", k), resolve_access_bits, 8'h00);
            @(negedge clk);
        end

        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
